// File: rtl/stream_logger_if.sv
// stream_logger_if
//   Bundle of the signals between stream_logger and the core-complex
//   down-port writers plus the readout client.
//
// Handshake (per lane i): the writer holds rready[i] high with a stable
// in[i] until it observes read[i] high, and it must drop rready[i] (or
// present the next word) in that same cycle. read[i] is a one-cycle accept
// pulse; rready[i] still high once read[i] has fallen is a new word.
//
// Ports (view from the logger, modport slave):
//   rready   in   LANES       writer has a valid word on in[i]
//   read     out  LANES       one-cycle accept pulse per word
//   in       in   LANES x W   lane data (signed)
//   limit    in   LANES x CW  expected stream length per lane
//   count    out  LANES x CW  words captured per lane
//   complete out  LANES       count[i] == limit[i]
//   overflow out  LANES       sticky: word arrived after completion
//   rd_en    in   1           readout request
//   rd_lane  in   2           readout lane select
//   rd_addr  in   CW          readout word index
//   rd_data  out  W           readout word
//   rd_valid out  1           rd_data valid
interface stream_logger_if #(
  parameter int LANES = 4,
  parameter int W     = 11,
  parameter int CW    = 6
);
  logic [LANES-1:0]         rready;
  logic [LANES-1:0]         read;
  logic [LANES-1:0][W-1:0]  in;
  logic [LANES-1:0][CW-1:0] limit;
  logic [LANES-1:0][CW-1:0] count;
  logic [LANES-1:0]         complete;
  logic [LANES-1:0]         overflow;
  logic                     rd_en;
  logic [1:0]               rd_lane;
  logic [CW-1:0]            rd_addr;
  logic [W-1:0]             rd_data;
  logic                     rd_valid;

  modport master (
    output rready, in, limit, rd_en, rd_lane, rd_addr,
    input  read, count, complete, overflow, rd_data, rd_valid
  );

  modport slave (
    input  rready, in, limit, rd_en, rd_lane, rd_addr,
    output read, count, complete, overflow, rd_data, rd_valid
  );
endinterface

// File: rtl/stream_logger.sv
// stream_logger
//   Reader end of the core-complex down-port. Each lane runs a small
//   WAIT/ACK FSM that captures one word per two cycles into that lane's
//   buffer, counts words against a programmed limit, and reports
//   completion. A registered random-access port reads captured words back.
//
//   Optional feature macro: STREAM_LOGGER_DRAIN_EN. When defined, words
//   offered to a complete (or full) lane are acknowledged through a DRAIN
//   state, discarded, and flag a sticky overflow. When undefined, such a
//   lane simply never acknowledges again and overflow is tied to 0.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   bus         stream_logger_if.slave (handshake, status, readout)
//   lane_state  per-lane FSM state, for debug/observation
module stream_logger #(
  parameter int LANES = 4,
  parameter int W     = 11,
  parameter int DEPTH = 39,
  parameter int CW    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_logger_if.slave        bus,
  output logic [LANES-1:0][1:0] lane_state
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ACK   = 2'd1
`ifdef STREAM_LOGGER_DRAIN_EN
    , S_DRAIN = 2'd2
`endif
  } lane_state_t;

  lane_state_t      state_q [LANES];
  lane_state_t      state_d [LANES];
  logic [CW-1:0]    count_q [LANES];
  logic [LANES-1:0] full;
  logic [LANES-1:0] capture;
`ifdef STREAM_LOGGER_DRAIN_EN
  logic [LANES-1:0] drain_hit;
  logic [LANES-1:0] overflow_q;
`endif

  // Buffers are deliberately not reset; count gating hides stale words.
  logic [W-1:0]     mem [LANES][DEPTH];
  logic [W-1:0]     rd_word;

  // Next-state logic. A lane refuses new words once it reaches its limit,
  // and also once its buffer is physically full, so count never exceeds
  // DEPTH even if limit was programmed larger.
  always_comb begin
    full    = '0;
    capture = '0;
`ifdef STREAM_LOGGER_DRAIN_EN
    drain_hit = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      state_d[l] = state_q[l];
      full[l]    = (count_q[l] == bus.limit[l]) || (count_q[l] == CW'(DEPTH));
      case (state_q[l])
        S_WAIT: begin
          if (bus.rready[l]) begin
            if (!full[l]) begin
              capture[l] = 1'b1;
              state_d[l] = S_ACK;
            end
`ifdef STREAM_LOGGER_DRAIN_EN
            else begin
              drain_hit[l] = 1'b1;
              state_d[l]   = S_DRAIN;
            end
`endif
          end
        end
        S_ACK:   state_d[l] = S_WAIT;
`ifdef STREAM_LOGGER_DRAIN_EN
        S_DRAIN: state_d[l] = S_WAIT;
`endif
        default: state_d[l] = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= S_WAIT;
        count_q[l] <= '0;
      end
`ifdef STREAM_LOGGER_DRAIN_EN
      overflow_q <= '0;
`endif
    end else begin
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= state_d[l];
        if (capture[l]) count_q[l] <= count_q[l] + CW'(1);
`ifdef STREAM_LOGGER_DRAIN_EN
        if (drain_hit[l]) overflow_q[l] <= 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (capture[l]) mem[l][count_q[l]] <= bus.in[l];
    end
  end

  // Readout compares against the registered (pre-capture) count, so the
  // word being written this cycle reads as 0. Unmatched lanes return 0.
  always_comb begin
    rd_word = '0;
    for (int l = 0; l < LANES; l++) begin
      if (bus.rd_lane == 2'(l) && bus.rd_addr < count_q[l]) begin
        rd_word = mem[l][bus.rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_word;
    end
  end

  // read is a decode of the registered state, so an async reset drops it
  // immediately.
  always_comb begin
    bus.read     = '0;
    bus.count    = '0;
    bus.complete = '0;
    lane_state   = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.read[l]     = (state_q[l] != S_WAIT);
      bus.count[l]    = count_q[l];
      bus.complete[l] = (count_q[l] == bus.limit[l]);
      lane_state[l]   = state_q[l];
    end
  end

`ifdef STREAM_LOGGER_DRAIN_EN
  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = '0;
`endif

endmodule

// File: tb/tb_stream_logger.sv
// tb_stream_logger
//   Self-checking bench for stream_logger. The reference model describes
//   each lane as "the first min(n, limit, DEPTH) offered words are stored";
//   acknowledge counts, overflow and readout values derive from that.
module tb_stream_logger;
  localparam int LANES = 4;
  localparam int W     = 11;
  localparam int DEPTH = 39;
  localparam int CW    = 6;
`ifdef STREAM_LOGGER_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_logger_if #(.LANES(LANES), .W(W), .CW(CW)) bus ();
  logic [LANES-1:0][1:0] lane_state;

  stream_logger #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .lane_state (lane_state)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int lim [LANES];
  int pulses [LANES];
  logic [W-1:0] tx_words [LANES][$];
  logic [W-1:0] exp_q [$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int accepted(input int n, input int lim_v);
    int a = n;
    if (a > lim_v) a = lim_v;
    if (a > DEPTH) a = DEPTH;
    return a;
  endfunction

  function automatic int acks(input int n, input int lim_v);
    return DRAIN ? n : accepted(n, lim_v);
  endfunction

  function automatic logic ovf(input int n, input int lim_v);
    return DRAIN && (n > accepted(n, lim_v));
  endfunction

  function automatic logic [W-1:0] model_word(input int lane, input int addr);
    if (lane < LANES && addr < accepted(tx_words[lane].size(), lim[lane]))
      return tx_words[lane][addr];
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst         = 1'b1;
    bus.rready  = '0;
    bus.in      = '0;
    bus.rd_en   = 1'b0;
    bus.rd_lane = '0;
    bus.rd_addr = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.limit[l] = CW'(lim[l]);
      tx_words[l].delete();
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Plays tx_words on all lanes concurrently with the proper handshake,
  // counting read pulses per lane; gives up after budget cycles.
  task automatic drive_lanes(input int budget);
    int  idx [LANES];
    bit  done;
    for (int l = 0; l < LANES; l++) begin
      idx[l]    = 0;
      pulses[l] = 0;
    end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      done = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        if (bus.read[l]) begin
          pulses[l]++;
          idx[l]++;
          bus.rready[l] = 1'b0;
        end else if (!bus.rready[l] && idx[l] < tx_words[l].size()) begin
          bus.rready[l] = 1'b1;
          bus.in[l]     = tx_words[l][idx[l]];
        end
        if (idx[l] < tx_words[l].size()) done = 1'b0;
      end
      if (done) break;
    end
    @(negedge clk);
    bus.rready = '0;
    @(negedge clk);
  endtask

  task automatic do_read(input int lane, input int addr, output logic [W-1:0] d, output logic v);
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.rd_lane = 2'(lane);
    bus.rd_addr = CW'(addr);
    @(negedge clk);
    d = bus.rd_data;
    v = bus.rd_valid;
    bus.rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    lim = '{3, 3, 3, 3};
    apply_reset();
    chk_cnt++;
    if (bus.read !== 4'b0) $display("FAIL reset_read: got %b expected 0000", bus.read); else pass_cnt++;
    chk_cnt++;
    if (bus.count !== '0) $display("FAIL reset_count: got %h expected 0", bus.count); else pass_cnt++;
    chk_cnt++;
    if (bus.overflow !== 4'b0) $display("FAIL reset_overflow: got %b expected 0000", bus.overflow); else pass_cnt++;
    chk_cnt++;
    if (bus.complete !== 4'b0) $display("FAIL reset_complete: got %b expected 0000", bus.complete); else pass_cnt++;
    chk_cnt++;
    if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0)
      $display("FAIL reset_readout: got data %h valid %b expected 0/0", bus.rd_data, bus.rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [W-1:0] d, e;
    logic v;
    lim = '{3, 3, 3, 3};
    apply_reset();
    for (int l = 0; l < LANES; l++) begin
      tx_words[l].push_back(W'(5));
      tx_words[l].push_back(W'(-7));
      tx_words[l].push_back(W'(999));
    end
    drive_lanes(40);
    for (int l = 0; l < LANES; l++) begin
      chk_cnt++;
      if (pulses[l] != acks(3, lim[l]))
        $display("FAIL basic_pulses lane %0d: got %0d expected %0d", l, pulses[l], acks(3, lim[l]));
      else pass_cnt++;
      chk_cnt++;
      if (bus.count[l] !== CW'(accepted(3, lim[l])))
        $display("FAIL basic_count lane %0d: got %0d expected %0d", l, bus.count[l], accepted(3, lim[l]));
      else pass_cnt++;
    end
    chk_cnt++;
    if (bus.complete !== 4'b1111) $display("FAIL basic_complete: got %b expected 1111", bus.complete); else pass_cnt++;
    for (int a = 0; a <= 3; a++) begin
      exp_q.push_back(model_word(2, a));
      do_read(2, a, d, v);
      e = exp_q.pop_front();
      chk_cnt++;
      if (d !== e || v !== 1'b1)
        $display("FAIL basic_readout addr %0d: got %h valid %b expected %h valid 1", a, d, v, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [4];
    logic [W-1:0] d, e;
    logic [7:0] pat, exp_pat;
    logic v;
    int k;
    lim = '{4, 3, 3, 3};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = W'($urandom_range(0, 2047));
      tx_words[0].push_back(w[i]);
    end
    // One word per two cycles: a pulse on every odd cycle until 4 words.
    exp_pat = '0;
    for (int c = 1; c <= 8; c++) if ((c % 2) == 1 && (c + 1) / 2 <= 4) exp_pat[c-1] = 1'b1;
    @(negedge clk);
    bus.rready[0] = 1'b1;
    bus.in[0]     = w[0];
    k   = 0;
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pat[c] = bus.read[0];
      if (bus.read[0]) begin
        k++;
        if (k < 4) bus.in[0] = w[k];
        else bus.rready[0] = 1'b0;
      end
    end
    bus.rready[0] = 1'b0;
    chk_cnt++;
    if (pat !== exp_pat) $display("FAIL b2b_pattern: got %b expected %b", pat, exp_pat); else pass_cnt++;
    chk_cnt++;
    if (bus.count[0] !== CW'(4) || bus.complete[0] !== 1'b1)
      $display("FAIL b2b_count: got %0d complete %b expected 4 complete 1", bus.count[0], bus.complete[0]);
    else pass_cnt++;
    for (int a = 0; a <= 4; a++) begin
      exp_q.push_back(model_word(0, a));
      do_read(0, a, d, v);
      e = exp_q.pop_front();
      chk_cnt++;
      if (d !== e || v !== 1'b1)
        $display("FAIL b2b_readout addr %0d: got %h valid %b expected %h valid 1", a, d, v, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] d, e;
    logic v;
    lim = '{3, 2, 3, 3};
    apply_reset();
    for (int i = 0; i < 3; i++) tx_words[1].push_back(W'($urandom_range(0, 2047)));
    drive_lanes(30);
    chk_cnt++;
    if (pulses[1] != acks(3, lim[1]))
      $display("FAIL ovf_pulses: got %0d expected %0d", pulses[1], acks(3, lim[1]));
    else pass_cnt++;
    chk_cnt++;
    if (bus.count[1] !== CW'(accepted(3, lim[1])) || bus.complete[1] !== 1'b1)
      $display("FAIL ovf_count: got %0d complete %b expected %0d complete 1", bus.count[1], bus.complete[1], accepted(3, lim[1]));
    else pass_cnt++;
    chk_cnt++;
    if (bus.overflow[1] !== ovf(3, lim[1]))
      $display("FAIL ovf_flag: got %b expected %b", bus.overflow[1], ovf(3, lim[1]));
    else pass_cnt++;
    exp_q.push_back(model_word(1, 2));
    do_read(1, 2, d, v);
    e = exp_q.pop_front();
    chk_cnt++;
    if (d !== e || v !== 1'b1) $display("FAIL ovf_readout: got %h valid %b expected %h valid 1", d, v, e); else pass_cnt++;
  endtask

  task automatic test_zero_limit();
    logic [W-1:0] d, e;
    logic v;
    lim = '{3, 3, 3, 0};
    apply_reset();
    chk_cnt++;
    if (bus.complete !== 4'b1000) $display("FAIL zero_complete: got %b expected 1000", bus.complete); else pass_cnt++;
    tx_words[3].push_back(W'($urandom_range(0, 2047)));
    drive_lanes(12);
    chk_cnt++;
    if (pulses[3] != acks(1, 0) || bus.count[3] !== CW'(0))
      $display("FAIL zero_capture: got pulses %0d count %0d expected pulses %0d count 0", pulses[3], bus.count[3], acks(1, 0));
    else pass_cnt++;
    chk_cnt++;
    if (bus.overflow[3] !== ovf(1, 0)) $display("FAIL zero_overflow: got %b expected %b", bus.overflow[3], ovf(1, 0)); else pass_cnt++;
    exp_q.push_back(model_word(3, 0));
    do_read(3, 0, d, v);
    e = exp_q.pop_front();
    chk_cnt++;
    if (d !== e || v !== 1'b1) $display("FAIL zero_readout: got %h valid %b expected %h valid 1", d, v, e); else pass_cnt++;
  endtask

  task automatic test_same_cycle_read();
    logic [W-1:0] w1, e;
    lim = '{3, 3, 3, 3};
    apply_reset();
    tx_words[0].push_back(W'($urandom_range(0, 2047)));
    drive_lanes(10);
    w1 = W'($urandom_range(1, 2047));
    exp_q.push_back(model_word(0, 1));
    @(negedge clk);
    bus.rready[0] = 1'b1;
    bus.in[0]     = w1;
    bus.rd_en     = 1'b1;
    bus.rd_lane   = 2'd0;
    bus.rd_addr   = CW'(1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk_cnt++;
    if (bus.rd_data !== e || bus.rd_valid !== 1'b1)
      $display("FAIL same_cycle_first: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, e);
    else pass_cnt++;
    chk_cnt++;
    if (bus.read[0] !== 1'b1) $display("FAIL same_cycle_ack: got %b expected 1", bus.read[0]); else pass_cnt++;
    bus.rready[0] = 1'b0;
    tx_words[0].push_back(w1);
    exp_q.push_back(model_word(0, 1));
    @(negedge clk);
    e = exp_q.pop_front();
    bus.rd_en = 1'b0;
    chk_cnt++;
    if (bus.rd_data !== e || bus.rd_valid !== 1'b1)
      $display("FAIL same_cycle_second: got %h valid %b expected %h valid 1", bus.rd_data, bus.rd_valid, e);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d, e;
    logic v;
    lim = '{3, 0, 3, 3};
    apply_reset();
    tx_words[0].push_back(W'($urandom_range(0, 2047)));
    tx_words[0].push_back(W'($urandom_range(0, 2047)));
    tx_words[1].push_back(W'($urandom_range(0, 2047)));
    drive_lanes(14);
    chk_cnt++;
    if (bus.count[0] !== CW'(2)) $display("FAIL mid_precount: got %0d expected 2", bus.count[0]); else pass_cnt++;
    @(negedge clk);
    bus.rready[0] = 1'b1;
    bus.in[0]     = W'($urandom_range(0, 2047));
    @(posedge clk);
    #2;
    chk_cnt++;
    if (bus.read[0] !== 1'b1) $display("FAIL mid_ack: got %b expected 1", bus.read[0]); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.read !== 4'b0 || bus.count !== '0 || bus.overflow !== 4'b0)
      $display("FAIL mid_async: got read %b count %h overflow %b expected all 0", bus.read, bus.count, bus.overflow);
    else pass_cnt++;
    bus.rready = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int l = 0; l < LANES; l++) tx_words[l].delete();
    exp_q.push_back(model_word(0, 0));
    do_read(0, 0, d, v);
    e = exp_q.pop_front();
    chk_cnt++;
    if (d !== e || v !== 1'b1) $display("FAIL mid_readout: got %h valid %b expected %h valid 1", d, v, e); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] d, e;
    logic [LANES-1:0] exp_c, exp_o;
    logic v;
    int n;
    for (int it = 0; it < 3; it++) begin
      for (int l = 0; l < LANES; l++) lim[l] = $urandom_range(0, 6);
      apply_reset();
      for (int l = 0; l < LANES; l++) begin
        n = $urandom_range(0, lim[l] + 2);
        for (int i = 0; i < n; i++) tx_words[l].push_back(W'($urandom_range(0, 2047)));
      end
      drive_lanes(40);
      for (int l = 0; l < LANES; l++) begin
        n        = tx_words[l].size();
        exp_c[l] = (accepted(n, lim[l]) == lim[l]);
        exp_o[l] = ovf(n, lim[l]);
        chk_cnt++;
        if (pulses[l] != acks(n, lim[l]) || bus.count[l] !== CW'(accepted(n, lim[l])))
          $display("FAIL rand_lane it %0d lane %0d: got pulses %0d count %0d expected pulses %0d count %0d",
                   it, l, pulses[l], bus.count[l], acks(n, lim[l]), accepted(n, lim[l]));
        else pass_cnt++;
      end
      chk_cnt++;
      if (bus.complete !== exp_c || bus.overflow !== exp_o)
        $display("FAIL rand_status it %0d: got complete %b overflow %b expected %b %b", it, bus.complete, bus.overflow, exp_c, exp_o);
      else pass_cnt++;
      for (int l = 0; l < LANES; l++) begin
        for (int a = 0; a < 8; a++) begin
          exp_q.push_back(model_word(l, a));
          do_read(l, a, d, v);
          e = exp_q.pop_front();
          chk_cnt++;
          if (d !== e || v !== 1'b1)
            $display("FAIL rand_readout it %0d lane %0d addr %0d: got %h valid %b expected %h valid 1", it, l, a, d, v, e);
          else pass_cnt++;
        end
      end
    end
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_zero_limit();
    test_same_cycle_read();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
